lut_cfg_ctrl: RTL and testbench

Configuration sequencer for the 16-entry x 4-bit LUT bank used in weight remapping. It takes a start command with a per-LUT select mask and accepts a 32-bit config stream, two beats per LUT table. It assembles each 64-bit table image and issues one write per selected LUT, lowest index first. While configuring, it holds the lookup datapath quiescent so that no lookup sees a half-updated bank.

---
 rtl/lut_cfg_ctrl_pkg.sv | 7 +
 rtl/lut_cfg_ctrl_prienc.sv | 15 +
 rtl/lut_cfg_ctrl.sv | 83 ++++++++
 tb/tb_lut_cfg_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_ctrl_pkg.sv
// lut_cfg_ctrl_pkg: shared state encoding and LUT bank geometry for the config sequencer
package lut_cfg_ctrl_pkg;
  localparam int LUT_ENTRY_W = 4;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IMG_W = LUT_ENTRY_W * LUT_DEPTH;
  typedef enum logic [2:0] {ST_IDLE, ST_DRAIN, ST_SEL, ST_LO, ST_HI, ST_WR, ST_DONE} state_t;
endpackage

// File: rtl/lut_cfg_ctrl_prienc.sv
// lut_cfg_ctrl_prienc: lowest-set-bit priority encoder with any-set flag
module lut_cfg_ctrl_prienc #(
  parameter int N = 16,
  parameter int W = 4
)(
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
  assign any = |req;
endmodule

// File: rtl/lut_cfg_ctrl.sv
// lut_cfg_ctrl: sequences two-beat table images into the selected LUTs while holding the lookup datapath
module lut_cfg_ctrl
  import lut_cfg_ctrl_pkg::*;
#(
  parameter int NUM_LUTS = 16,
  parameter int LUT_ID_W = 4,
  parameter int BEAT_W = 32
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [NUM_LUTS-1:0]  cfg_lut_mask,
  input  logic                 cfg_abort,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  input  logic [BEAT_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 dp_idle,
  output logic                 dp_hold,
  output logic                 lut_cfg_update,
  output logic [LUT_IMG_W-1:0] lut_wr_data,
  output logic                 lut_wr_valid,
  output logic [LUT_ID_W-1:0]  lut_wr_id
);
  state_t state, nxt;
  logic [NUM_LUTS-1:0] rem_mask;
  logic [LUT_ID_W-1:0] cur_id, enc_idx;
  logic enc_any;
  logic [BEAT_W-1:0] lo_beat;
  lut_cfg_ctrl_prienc #(.N(NUM_LUTS), .W(LUT_ID_W)) u_prienc (
    .req(rem_mask),
    .idx(enc_idx),
    .any(enc_any)
  );
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = !cfg_start ? ST_IDLE : (|cfg_lut_mask ? ST_DRAIN : ST_DONE);
      ST_DRAIN: nxt = dp_idle ? ST_SEL : ST_DRAIN;
      ST_SEL:   nxt = enc_any ? ST_LO : ST_DONE;
      ST_LO:    nxt = s_valid ? ST_HI : ST_LO;
      ST_HI:    nxt = s_valid ? ST_WR : ST_HI;
      ST_WR:    nxt = ST_SEL;
      default:  nxt = ST_IDLE;
    endcase
    if (cfg_abort && state != ST_IDLE) nxt = ST_IDLE;
  end
  // Outputs are decoded from the next state so they are registered yet aligned with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      dp_hold <= 1'b0;
      s_ready <= 1'b0;
      lut_cfg_update <= 1'b0;
      lut_wr_valid <= 1'b0;
      lut_wr_id <= '0;
      lut_wr_data <= '0;
      rem_mask <= '0;
      cur_id <= '0;
      lo_beat <= '0;
    end else begin
      state <= nxt;
      cfg_busy <= nxt != ST_IDLE;
      cfg_done <= nxt == ST_DONE;
      dp_hold <= nxt != ST_IDLE && !(state == ST_IDLE && nxt == ST_DONE);
      s_ready <= nxt == ST_LO || nxt == ST_HI;
      lut_cfg_update <= nxt inside {ST_SEL, ST_LO, ST_HI, ST_WR};
      lut_wr_valid <= nxt == ST_WR;
      if (state == ST_IDLE && cfg_start) rem_mask <= cfg_lut_mask;
      else if (cfg_abort) rem_mask <= '0;
      else if (state == ST_WR) rem_mask[cur_id] <= 1'b0;
      if (state == ST_SEL) cur_id <= enc_idx;
      if (state == ST_LO && s_valid) lo_beat <= s_data;
      if (nxt == ST_WR) begin
        lut_wr_id <= cur_id;
        lut_wr_data <= {s_data, lo_beat};
      end
    end
  end
endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// tb_lut_cfg_ctrl: randomized scenario bench comparing LUT writes against a mask/beat reference model
module tb_lut_cfg_ctrl;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_abort = 0, s_valid = 0, dp_idle = 1;
  logic [15:0] cfg_lut_mask = '0;
  logic [31:0] s_data = '0;
  logic cfg_busy, cfg_done, s_ready, dp_hold, lut_cfg_update, lut_wr_valid;
  logic [63:0] lut_wr_data;
  logic [3:0] lut_wr_id;
  int pass_cnt = 0, total = 0, cyc = 0, done_cnt = 0, wr_cyc = 0, done_cyc = 0;
  logic [3:0] got_id[$];
  logic [63:0] got_data[$];

  lut_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_lut_mask(cfg_lut_mask),
    .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp_idle(dp_idle), .dp_hold(dp_hold), .lut_cfg_update(lut_cfg_update),
    .lut_wr_data(lut_wr_data), .lut_wr_valid(lut_wr_valid), .lut_wr_id(lut_wr_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (lut_wr_valid) begin
      got_id.push_back(lut_wr_id);
      got_data.push_back(lut_wr_data);
      wr_cyc = cyc;
    end
    if (cfg_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic send_beat(input logic [31:0] d, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    s_valid = 1;
    s_data = d;
    t = 0;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      total++;
      $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic run_seq(input logic [15:0] mask, input int gap, input int drain,
                         input bit busy_start, input bit fixed, input string tag);
    logic [31:0] beats[$];
    logic [3:0] exp_id[$];
    logic [63:0] exp_data[$];
    int k, t;
    for (int i = 0; i < 2 * $countones(mask); i++) beats.push_back($urandom);
    if (fixed) begin
      beats[0] = 32'h76543210;
      beats[1] = 32'hFEDCBA98;
    end
    k = 0;
    for (int i = 0; i < 16; i++)
      if (mask[i]) begin
        exp_id.push_back(4'(i));
        exp_data.push_back({beats[2*k+1], beats[2*k]});
        k++;
      end
    got_id.delete();
    got_data.delete();
    done_cnt = 0;
    dp_idle = (drain == 0);
    @(negedge clk);
    cfg_start = 1;
    cfg_lut_mask = mask;
    @(negedge clk);
    cfg_start = 0;
    cfg_lut_mask = 16'($urandom);
    for (int i = 0; i < drain; i++) begin
      total++;
      if ({dp_hold, s_ready, lut_wr_valid} !== 3'b100) $display("FAIL %s drain: hold/ready/wr=%b required 100", tag, {dp_hold, s_ready, lut_wr_valid});
      else pass_cnt++;
      @(negedge clk);
    end
    dp_idle = 1;
    foreach (beats[i]) begin
      send_beat(beats[i], gap);
      if (busy_start && i == 0) begin
        cfg_start = 1;
        cfg_lut_mask = 16'hFFFF;
        @(negedge clk);
        cfg_start = 0;
      end
    end
    t = 0;
    while (!cfg_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (cfg_done !== 1'b1) $display("FAIL %s done_timeout: cfg_done=%b required 1", tag, cfg_done);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({cfg_busy, dp_hold, cfg_done} !== 3'b000) $display("FAIL %s post_done: busy/hold/done=%b required 000", tag, {cfg_busy, dp_hold, cfg_done});
    else pass_cnt++;
    total++;
    if (got_id.size() !== exp_id.size()) $display("FAIL %s strobes: got %0d required %0d", tag, got_id.size(), exp_id.size());
    else pass_cnt++;
    for (int i = 0; i < exp_id.size() && i < got_id.size(); i++) begin
      total++;
      if (got_id[i] !== exp_id[i] || got_data[i] !== exp_data[i])
        $display("FAIL %s write%0d: got id=%0d data=%h required id=%0d data=%h", tag, i, got_id[i], got_data[i], exp_id[i], exp_data[i]);
      else pass_cnt++;
    end
    total++;
    if (done_cnt !== 1) $display("FAIL %s done_count: got %0d required 1", tag, done_cnt);
    else pass_cnt++;
    total++;
    if (done_cyc - wr_cyc !== 2) $display("FAIL %s done_latency: got %0d required 2", tag, done_cyc - wr_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({cfg_busy, cfg_done, s_ready, dp_hold, lut_cfg_update, lut_wr_valid, lut_wr_id, lut_wr_data} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b rdy=%b hold=%b upd=%b wv=%b id=%0d data=%h required all 0",
               cfg_busy, cfg_done, s_ready, dp_hold, lut_cfg_update, lut_wr_valid, lut_wr_id, lut_wr_data);
    else pass_cnt++;
    rst_n = 1;
    got_id.delete();
    @(negedge clk);
    cfg_start = 1;
    cfg_lut_mask = 16'h0001;
    @(negedge clk);
    cfg_start = 0;
    send_beat($urandom, 0);
    rst_n = 0;
    #1;
    total++;
    if ({cfg_busy, dp_hold, s_ready, lut_cfg_update} !== 4'b0000) $display("FAIL reset_mid: busy/hold/rdy/upd=%b required 0000", {cfg_busy, dp_hold, s_ready, lut_cfg_update});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    s_valid = 1;
    repeat (4) @(negedge clk);
    s_valid = 0;
    total++;
    if (got_id.size() !== 0 || cfg_busy !== 1'b0) $display("FAIL reset_no_write: got strobes=%0d busy=%b required 0 0", got_id.size(), cfg_busy);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    run_seq(16'h0001, 0, 0, 0, 1, "basic");
    @(negedge clk);
    total++;
    if (lut_wr_data !== 64'hFEDCBA9876543210 || lut_wr_id !== 4'd0)
      $display("FAIL basic_hold: got id=%0d data=%h required 0 fedcba9876543210", lut_wr_id, lut_wr_data);
    else pass_cnt++;
  endtask

  task automatic test_sparse;
    run_seq(16'h8421, 0, 0, 0, 0, "sparse");
  endtask

  task automatic test_drain;
    run_seq(16'h0010, 0, 5, 0, 0, "drain");
  endtask

  task automatic test_backpressure;
    run_seq(16'h0240, 3, 0, 0, 0, "gaps");
  endtask

  task automatic test_abort;
    got_id.delete();
    done_cnt = 0;
    dp_idle = 1;
    @(negedge clk);
    cfg_start = 1;
    cfg_lut_mask = 16'h0003;
    @(negedge clk);
    cfg_start = 0;
    send_beat($urandom, 0);
    cfg_abort = 1;
    @(negedge clk);
    cfg_abort = 0;
    total++;
    if ({cfg_busy, dp_hold} !== 2'b00) $display("FAIL abort_idle: busy/hold=%b required 00", {cfg_busy, dp_hold});
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total++;
    if (got_id.size() !== 0 || done_cnt !== 0) $display("FAIL abort_quiet: got strobes=%0d done=%0d required 0 0", got_id.size(), done_cnt);
    else pass_cnt++;
    run_seq(16'h0002, 0, 0, 0, 0, "abort_restart");
  endtask

  task automatic test_zero_and_busy;
    @(negedge clk);
    cfg_start = 1;
    cfg_lut_mask = 16'h0000;
    @(negedge clk);
    cfg_start = 0;
    total++;
    if ({cfg_done, cfg_busy, dp_hold} !== 3'b110) $display("FAIL zero_done: done/busy/hold=%b required 110", {cfg_done, cfg_busy, dp_hold});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({cfg_done, cfg_busy, dp_hold} !== 3'b000) $display("FAIL zero_after: done/busy/hold=%b required 000", {cfg_done, cfg_busy, dp_hold});
    else pass_cnt++;
    run_seq(16'h0006, 0, 0, 1, 0, "busy_start");
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++)
      run_seq(16'($urandom_range(1, 65535)), $urandom_range(0, 2), $urandom_range(0, 3), 0, 0, "random");
    run_seq(16'hFFFF, 0, 0, 0, 0, "all_ones");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sparse;
    test_drain;
    test_backpressure;
    test_abort;
    test_zero_and_busy;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
